// File: rtl/retinex_norm_lut_stream.sv
// Streaming retinex normalisation: CH log-domain samples mapped through a reloadable LUT, 2-stage valid/ready pipe.
// Optional per-sample table bypass (plain right shift) when RETINEX_NORM_BYPASS_EN is defined.
module retinex_norm_lut_stream #(
  parameter int    IN_W      = 10,
  parameter int    OUT_W     = 8,
  parameter int    CH        = 1,
  parameter int    USER_W    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                clka,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH*IN_W-1:0]  s_data,
  input  logic [USER_W-1:0]   s_user,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH*OUT_W-1:0] m_data,
  output logic [USER_W-1:0]   m_user,
`ifdef RETINEX_NORM_BYPASS_EN
  input  logic                cfg_bypass,
`endif
  input  logic                cfg_we,
  input  logic [IN_W-1:0]     cfg_addr,
  input  logic [OUT_W-1:0]    cfg_wdata,
  output logic [15:0]         cfg_wr_cnt
);

  localparam int DEPTH = 1 << IN_W;
  localparam int SH    = IN_W - OUT_W;

  logic                v1;
  logic [USER_W-1:0]   u1;
  logic                adv1;
  logic                adv2;
  logic                xfer;
  logic                byp;
  logic [CH*OUT_W-1:0] rd_bus;

  assign adv2    = !m_valid || m_ready;
  assign adv1    = !v1 || adv2;
  assign s_ready = adv1 && !cfg_we;
  assign xfer    = s_valid && s_ready;

`ifdef RETINEX_NORM_BYPASS_EN
  assign byp = cfg_bypass;
`else
  assign byp = 1'b0;
`endif

  // One table copy per channel so every channel has its own read port; writes go to all copies.
  // Reads happen only on an accepted sample, so a stalled stage-1 word is never overwritten.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] rd_q;
    logic [IN_W-1:0]  raddr;

    assign raddr                    = s_data[k*IN_W +: IN_W];
    assign rd_bus[k*OUT_W +: OUT_W] = rd_q;

    initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = OUT_W'(i >> SH);
    end

    always_ff @(posedge clka) begin
      if (cfg_we) mem[cfg_addr] <= cfg_wdata;
      if (xfer) rd_q <= byp ? OUT_W'(raddr >> SH) : mem[raddr];
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      u1         <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_user     <= '0;
      cfg_wr_cnt <= '0;
    end else begin
      if (adv1) begin
        v1 <= xfer;
        if (xfer) u1 <= s_user;
      end
      // Output registers keep their last contents across bubbles.
      if (adv2) begin
        m_valid <= v1;
        if (v1) begin
          m_data <= rd_bus;
          m_user <= u1;
        end
      end
      if (cfg_we) cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_retinex_norm_lut_stream.sv
// Bench for retinex_norm_lut_stream: directed scenarios plus randomized traffic against a table/queue model.
module tb_retinex_norm_lut_stream;
  localparam int IN_W = 10, OUT_W = 8, CH = 2, USER_W = 2;

  logic                clka = 1'b0;
  logic                rst_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [CH*IN_W-1:0]  s_data = '0;
  logic [USER_W-1:0]   s_user = '0;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [CH*OUT_W-1:0] m_data;
  logic [USER_W-1:0]   m_user;
  logic                cfg_bypass = 1'b0;
  logic                cfg_we = 1'b0;
  logic [IN_W-1:0]     cfg_addr = '0;
  logic [OUT_W-1:0]    cfg_wdata = '0;
  logic [15:0]         cfg_wr_cnt;

  retinex_norm_lut_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .USER_W(USER_W)) dut (
    .clka(clka), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
`ifdef RETINEX_NORM_BYPASS_EN
    .cfg_bypass(cfg_bypass),
`endif
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr_cnt(cfg_wr_cnt)
  );

  always #5 clka = ~clka;

  int vectors = 0;
  int miscompares = 0;
  int out_cnt = 0;
  int wr_cnt_m = 0;
  logic [7:0]  tbl [1024];
  logic [17:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Expected {user, code1, code0}: table value current at acceptance, or value/4 when bypassed.
  function automatic logic [17:0] model(input logic [19:0] d, input logic [1:0] u, input logic b);
    logic [15:0] o;
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(d[k*10 +: 10]);
      o[k*8 +: 8] = b ? 8'(a / 4) : tbl[a];
    end
    return {u, o};
  endfunction

  function automatic logic [9:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return 10'd0;
      1:       return 10'd1023;
      default: return 10'($urandom);
    endcase
  endfunction

  always @(negedge clka) begin
    if (rst_n) begin
      if (m_valid) begin
        if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          check("out", {m_user, m_data}, exp_q[0]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(model(s_data, s_user, cfg_bypass));
      if (cfg_we) begin
        tbl[cfg_addr] = cfg_wdata;
        wr_cnt_m = (wr_cnt_m + 1) % 65536;
      end
    end
  end

  task automatic send(input logic [19:0] d, input logic [1:0] u);
    bit done = 0;
    s_valid = 1'b1; s_data = d; s_user = u;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clka); done = s_ready;
      @(posedge clka); #1;
    end
    s_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg_write(input logic [9:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clka); check("wr_s_ready", s_ready, 0);
    @(posedge clka); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clka); #1;
    end
    @(posedge clka); #2;
    check("drain_empty", exp_q.size(), 0);
    check("drain_mvalid", m_valid, 0);
    check("wr_cnt", cfg_wr_cnt, wr_cnt_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 1024; i++) tbl[i] = 8'(i / 4);

    #3;
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_muser", m_user, 0);
    check("rst_wrcnt", cfg_wr_cnt, 0);
    @(posedge clka); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;

    // identity table, boundary address 1023 and 2-cycle latency
    send({10'd1023, 10'd4}, 2'b01);
    @(negedge clka); check("lat1_mvalid", m_valid, 0);
    @(negedge clka); check("lat2_mvalid", m_valid, 1);
    check("t1_data", m_data, 16'hFF01);
    drain();

    // reload then immediate read
    cfg_write(10'd512, 8'hA5);
    send({10'd512, 10'd512}, 2'b10);
    check("t2_wrcnt", cfg_wr_cnt, 16'd1);
    @(negedge clka); @(negedge clka);
    check("t2_data", m_data, 16'hA5A5);
    drain();

    // write right behind an in-flight read
    send({10'd5, 10'd5}, 2'b11);
    cfg_write(10'd5, 8'h3C);
    @(negedge clka);
    check("t3_old_valid", m_valid, 1);
    check("t3_old_data", m_data, 16'h0101);
    send({10'd5, 10'd5}, 2'b00);
    @(negedge clka); @(negedge clka);
    check("t3_new_data", m_data, 16'h3C3C);
    drain();

    // backpressure with m_ready 1,0,0,1
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send({10'(i * 4), 10'(i * 4)}, 2'(i));
      end
      begin
        for (int j = 0; j < 40; j++) begin
          m_ready = pat[j % 4];
          @(posedge clka); #1;
        end
      end
    join
    drain();
    check("t4_count", out_cnt - base, 8);

    // reset with two samples in flight
    m_ready = 1'b0;
    send({10'd512, 10'd512}, 2'b01);
    send({10'd4, 10'd4}, 2'b10);
    @(posedge clka); #3;
    rst_n = 1'b0;
    #1;
    check("t5_mvalid", m_valid, 0);
    check("t5_wrcnt", cfg_wr_cnt, 0);
    exp_q.delete();
    wr_cnt_m = 0;
    @(posedge clka); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    send({10'd512, 10'd1023}, 2'b00);
    @(negedge clka); @(negedge clka);
    check("t5_retained", m_data, 16'hA5FF);
    drain();

`ifdef RETINEX_NORM_BYPASS_EN
    cfg_bypass = 1'b1;
    send({10'd512, 10'd512}, 2'b01);
    cfg_bypass = 1'b0;
    @(negedge clka); @(negedge clka);
    check("t6_bypass", m_data, 16'h8080);
    drain();
`endif

    for (int c = 0; c < 400; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = {rnd_addr(), rnd_addr()};
      s_user    = 2'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = rnd_addr();
      cfg_wdata = 8'($urandom);
`ifdef RETINEX_NORM_BYPASS_EN
      cfg_bypass = 1'($urandom);
`endif
      @(posedge clka); #1;
    end
    cfg_we = 1'b0;
    cfg_bypass = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
